// File: rtl/cnt_run_engine.sv
// Cycle-count worker: on an accepted start it runs for i_num_cnt cycles, then pulses o_done.
// Optional abort input is enabled by defining CNT_ABORT_EN.
module cnt_run_engine #(
  parameter int unsigned CNT_WIDTH = 7
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 i_run,
  input  logic [CNT_WIDTH-1:0] i_num_cnt,
`ifdef CNT_ABORT_EN
  input  logic                 i_abort,
`endif
  output logic                 o_idle,
  output logic                 o_running,
  output logic                 o_done,
  output logic [CNT_WIDTH-1:0] o_cnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic [CNT_WIDTH-1:0] w_cnt_nxt;
  logic [CNT_WIDTH-1:0] r_num_cnt;
  logic [CNT_WIDTH-1:0] w_num_cnt_nxt;
  logic                 w_abort;
  logic                 w_terminal;

`ifdef CNT_ABORT_EN
  assign w_abort = i_abort;
`else
  assign w_abort = 1'b0;
`endif

  // r_num_cnt is never zero while in S_RUN, so the subtraction cannot underflow.
  assign w_terminal = (r_cnt == (r_num_cnt - 1'b1));

  always_comb begin
    w_state_nxt   = S_IDLE;
    w_cnt_nxt     = '0;
    w_num_cnt_nxt = r_num_cnt;
    case (r_state)
      S_IDLE: begin
        if (i_run && (i_num_cnt != '0)) begin
          w_state_nxt   = S_RUN;
          w_num_cnt_nxt = i_num_cnt;
        end
      end
      S_RUN: begin
        if (w_abort) begin
          w_state_nxt = S_IDLE;
        end else if (w_terminal) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_RUN;
          w_cnt_nxt   = r_cnt + 1'b1;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_num_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_num_cnt <= w_num_cnt_nxt;
    end
  end

  always_comb begin
    o_idle    = 1'b0;
    o_running = 1'b0;
    o_done    = 1'b0;
    o_cnt     = '0;
    case (r_state)
      S_IDLE: o_idle = 1'b1;
      S_RUN: begin
        o_running = 1'b1;
        o_cnt     = r_cnt;
      end
      S_DONE:  o_done = 1'b1;
      default: o_idle = 1'b0;
    endcase
  end

endmodule
